hazard_stall_unit: RTL and testbench

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

---
 rtl/hazard_stall_unit.sv | 122 ++++++++++++
 tb/tb_hazard_stall_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// Load-use and ID-branch hazard detection with multi-cycle stall sequencing.
// Define HAZARD_BRANCH_ID_EN to enable the branch hazards resolved in ID.
module hazard_stall_unit #(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_branch,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_memread,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              flush,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic              stall_active,
  output logic [15:0]       stall_count
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] STALL = 1'b1;

  localparam logic [3:0] LS  = 4'(LOAD_STALL);
  localparam logic [3:0] LS1 = 4'(LOAD_STALL + 1);

  logic [0:0] state;
  logic [3:0] cnt;
  logic [3:0] need;
  logic       exHit;
  logic       hazard;
  logic       stall;

  function automatic logic match(
    input logic              useFlag,
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] dst,
    input logic              wr
  );
    return useFlag && (src == dst) && (dst != '0) && wr;
  endfunction

`ifdef HAZARD_BRANCH_ID_EN
  logic memHit;
`else
  logic unusedBranchIns;
  assign unusedBranchIns =
    ^{id_is_branch, mem_memread, mem_regwrite, mem_rd};
`endif

  // need = largest stall length among all coexisting hazards
  always_comb begin
    need  = 4'd0;
    exHit = match(id_uses_rs, id_rs, ex_rd, ex_regwrite)
          | match(id_uses_rt, id_rt, ex_rd, ex_regwrite);
    if (ex_memread && exHit && LS > need)
      need = LS;
`ifdef HAZARD_BRANCH_ID_EN
    memHit = match(id_uses_rs, id_rs, mem_rd, mem_regwrite)
           | match(id_uses_rt, id_rt, mem_rd, mem_regwrite);
    if (id_is_branch) begin
      if (exHit && !ex_memread && need < 4'd1)
        need = 4'd1;
      if (exHit && ex_memread && LS1 > need)
        need = LS1;
      if (mem_memread && memHit && LS > need)
        need = LS;
    end
`endif
  end

  assign hazard = (state == IDLE) && id_valid && !flush
                && (need != 4'd0);

  assign stall = reset
               && (hazard || (state == STALL && !flush));

  assign pc_write     = !stall;
  assign ifid_write   = !stall;
  assign stall_active = stall;
  assign idex_bubble  = reset && (stall || flush);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      stall_count <= 16'd0;
    end else begin
      if (stall && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
      unique case (1'b1)
        (state == IDLE): begin
          if (hazard && need > 4'd1) begin
            state <= STALL;
            cnt   <= need - 4'd1;
          end
        end
        (state == STALL): begin
          if (flush || cnt <= 4'd1) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench: three instances with LOAD_STALL = 1, 2, 3 on shared inputs.
// Branch expectations follow HAZARD_BRANCH_ID_EN at compile time.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       idValid, usesRs, usesRt, isBranch;
  logic [4:0] idRs, idRt, exRd, memRd;
  logic       exRegwrite, exMemread, memMemread, memRegwrite;
  logic       flush;

  logic        pcW    [3];
  logic        ifidW  [3];
  logic        bubble [3];
  logic        active [3];
  logic [15:0] stCnt  [3];

  int nVec = 0;
  int nBad = 0;

`ifdef HAZARD_BRANCH_ID_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gDut
    hazard_stall_unit #(.REG_AW(5), .LOAD_STALL(g + 1)) u (
      .clk(clk), .reset(reset),
      .id_valid(idValid), .id_rs(idRs), .id_rt(idRt),
      .id_uses_rs(usesRs), .id_uses_rt(usesRt),
      .id_is_branch(isBranch),
      .ex_regwrite(exRegwrite), .ex_memread(exMemread),
      .ex_rd(exRd),
      .mem_memread(memMemread), .mem_regwrite(memRegwrite),
      .mem_rd(memRd), .flush(flush),
      .pc_write(pcW[g]), .ifid_write(ifidW[g]),
      .idex_bubble(bubble[g]), .stall_active(active[g]),
      .stall_count(stCnt[g])
    );
  end

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    nVec++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clearIns();
    idValid = 0; usesRs = 0; usesRt = 0; isBranch = 0;
    idRs = 0; idRt = 0; exRd = 0; memRd = 0;
    exRegwrite = 0; exMemread = 0;
    memMemread = 0; memRegwrite = 0; flush = 0;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 0;
    clearIns();
    @(negedge clk);
    reset = 1;
  endtask

  task automatic loadUse(input logic [4:0] r);
    idValid = 1; usesRs = 1; idRs = r;
    exMemread = 1; exRegwrite = 1; exRd = r;
  endtask

  // hazard inputs held for one cycle, then cleared
  task automatic runN(input string tag,
                      input int n0, input int n1, input int n2);
    int n [3];
    n[0] = n0; n[1] = n1; n[2] = n2;
    for (int c = 0; c < 6; c++) begin
      #2;
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("%s act g%0d c%0d", tag, g, c),
            16'(active[g]), 16'(c < n[g]));
        chk($sformatf("%s pcw g%0d c%0d", tag, g, c),
            16'(pcW[g]), 16'(!(c < n[g])));
      end
      @(negedge clk);
      clearIns();
    end
    for (int g = 0; g < 3; g++)
      chk($sformatf("%s cnt g%0d", tag, g), stCnt[g], 16'(n[g]));
  endtask

  initial begin
    clearIns();
    flush = 1;
    loadUse(5'd5);
    #3;
    for (int g = 0; g < 3; g++) begin
      chk("rst pcw", 16'(pcW[g]), 16'd1);
      chk("rst ifid", 16'(ifidW[g]), 16'd1);
      chk("rst bub", 16'(bubble[g]), 16'd0);
      chk("rst act", 16'(active[g]), 16'd0);
      chk("rst cnt", stCnt[g], 16'd0);
    end

    // single load-use stall with LOAD_STALL=1
    doReset();
    loadUse(5'd5);
    #2;
    chk("lu1 pcw", 16'(pcW[0]), 16'd0);
    chk("lu1 ifid", 16'(ifidW[0]), 16'd0);
    chk("lu1 bub", 16'(bubble[0]), 16'd1);
    @(negedge clk);
    clearIns();
    #2;
    chk("lu1 resume", 16'(pcW[0]), 16'd1);
    chk("lu1 bub off", 16'(bubble[0]), 16'd0);
    chk("lu1 cnt", stCnt[0], 16'd1);

    // r0 never matches
    doReset();
    loadUse(5'd0);
    #2;
    for (int g = 0; g < 3; g++)
      chk("r0 pcw", 16'(pcW[g]), 16'd1);

    // no regwrite -> no match
    doReset();
    loadUse(5'd9);
    exRegwrite = 0;
    #2;
    chk("nowr act", 16'(active[2]), 16'd0);

    // idle id stage -> no hazard
    doReset();
    loadUse(5'd9);
    idValid = 0;
    #2;
    chk("novld act", 16'(active[2]), 16'd0);

    doReset();
    loadUse(5'd6);
    runN("lu", 1, 2, 3);

    // load-use via rt
    doReset();
    idValid = 1; usesRt = 1; idRt = 5'd12;
    exMemread = 1; exRegwrite = 1; exRd = 5'd12;
    runN("lurt", 1, 2, 3);

    // branch on EX load result via rt
    doReset();
    idValid = 1; isBranch = 1; usesRt = 1; idRt = 5'd7;
    exMemread = 1; exRegwrite = 1; exRd = 5'd7;
    runN("brld", 1 + BR, 2 + BR, 3 + BR);

    // branch on EX ALU result via rs
    doReset();
    idValid = 1; isBranch = 1; usesRs = 1; idRs = 5'd3;
    exRegwrite = 1; exRd = 5'd3;
    runN("bralu", BR, BR, BR);

    // branch on MEM load result
    doReset();
    idValid = 1; isBranch = 1; usesRs = 1; idRs = 5'd4;
    memMemread = 1; memRegwrite = 1; memRd = 5'd4;
    runN("brmem", BR * 1, BR * 2, BR * 3);

    // flush in IDLE with hazard
    doReset();
    loadUse(5'd8);
    flush = 1;
    #2;
    chk("flidle act", 16'(active[2]), 16'd0);
    chk("flidle bub", 16'(bubble[2]), 16'd1);
    chk("flidle pcw", 16'(pcW[2]), 16'd1);

    // flush in 2nd stall cycle, LOAD_STALL=3
    doReset();
    loadUse(5'd5);
    #2;
    chk("fl c1 act", 16'(active[2]), 16'd1);
    @(negedge clk);
    clearIns();
    flush = 1;
    #2;
    chk("fl c2 act", 16'(active[2]), 16'd0);
    chk("fl c2 bub", 16'(bubble[2]), 16'd1);
    @(negedge clk);
    flush = 0;
    #2;
    chk("fl c3 act", 16'(active[2]), 16'd0);
    chk("fl c3 pcw", 16'(pcW[2]), 16'd1);
    chk("fl cnt", stCnt[2], 16'd1);

    // reset mid-stall, then fresh evaluation
    doReset();
    loadUse(5'd5);
    @(negedge clk);
    clearIns();
    #2;
    chk("rs c2 act", 16'(active[2]), 16'd1);
    reset = 0;
    #1;
    chk("rs pcw", 16'(pcW[2]), 16'd1);
    chk("rs act", 16'(active[2]), 16'd0);
    chk("rs cnt", stCnt[2], 16'd0);
    @(negedge clk);
    reset = 1;
    loadUse(5'd5);
    #2;
    chk("rs fresh", 16'(active[2]), 16'd1);
    @(negedge clk);
    clearIns();
    #2;
    chk("rs fresh c2", 16'(active[0]), 16'd0);

    // saturation of the stall counter
    doReset();
    loadUse(5'd10);
    repeat (65540) @(negedge clk);
    #2;
    chk("sat cnt", stCnt[0], 16'hFFFF);
    chk("sat act", 16'(active[0]), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             nVec, nBad);
    $finish;
  end

endmodule
